// File: rtl/lc3_decode_pkg.sv
// Shared opcode values, control-field encodings and the queued entry layout
// for the LC3 decode queue.
package lc3_decode_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_NOT = 2'b10;

  localparam logic [1:0] PC1_NONE  = 2'b00;
  localparam logic [1:0] PC1_PCOFF = 2'b01;
  localparam logic [1:0] PC1_BASE  = 2'b10;
  localparam logic [1:0] PC1_JMP   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  typedef struct packed {
    logic [15:0] ir;
    logic [5:0]  e_ctrl;
    logic [1:0]  w_ctrl;
    logic        mem_ctrl;
  } decode_entry_t;

  // E_Control bit order is {alu[1:0], pcselect1[1:0], pcselect2, op2select}.
  function automatic logic [5:0] pack_e_ctrl(logic [1:0] alu, logic [1:0] pc1,
                                             logic pc2, logic op2);
    return {alu, pc1, pc2, op2};
  endfunction

endpackage

// File: rtl/lc3_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
interface lc3_decode_queue_if #(parameter int ADDR_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instr_in;
  logic [ADDR_W-1:0] npc_in;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       IR;
  logic [ADDR_W-1:0] npc_out;
  logic [5:0]        E_Control;
  logic [1:0]        W_Control;
  logic              Mem_Control;

  modport master (
    output in_valid, instr_in, npc_in, out_ready,
    input  in_ready, out_valid, IR, npc_out, E_Control, W_Control, Mem_Control
  );

  modport slave (
    input  in_valid, instr_in, npc_in, out_ready,
    output in_ready, out_valid, IR, npc_out, E_Control, W_Control, Mem_Control
  );
endinterface

// File: rtl/lc3_decode_logic.sv
// Combinational LC3 instruction decoder feeding the queue write port.
module lc3_decode_logic
  import lc3_decode_pkg::*;
(
  input  logic [15:0] instr,
  output logic [5:0]  e_ctrl,
  output logic [1:0]  w_ctrl,
  output logic        mem_ctrl,
  output logic        is_illegal
);

  logic [1:0] alu;
  logic [1:0] pc1;
  logic       pc2;
  logic       op2;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu        = ALU_ADD;
    pc1        = PC1_NONE;
    pc2        = 1'b0;
    op2        = 1'b0;
    w_ctrl     = WB_ALU;
    mem_ctrl   = 1'b0;
    is_illegal = 1'b0;
    case (instr[15:12])
      OP_ADD: begin alu = ALU_ADD; op2 = ~instr[5]; end
      OP_AND: begin alu = ALU_AND; op2 = ~instr[5]; end
      OP_NOT: alu = ALU_NOT;
      OP_BR, OP_ST: begin pc1 = PC1_PCOFF; pc2 = 1'b1; end
      OP_LD:  begin pc1 = PC1_PCOFF; pc2 = 1'b1; w_ctrl = WB_MEM; end
      OP_LDI: begin pc1 = PC1_PCOFF; pc2 = 1'b1; w_ctrl = WB_MEM; mem_ctrl = 1'b1; end
      OP_STI: begin pc1 = PC1_PCOFF; pc2 = 1'b1; mem_ctrl = 1'b1; end
      OP_LEA: begin pc1 = PC1_PCOFF; pc2 = 1'b1; w_ctrl = WB_PC; end
      OP_LDR: begin pc1 = PC1_BASE; w_ctrl = WB_MEM; end
      OP_STR: pc1 = PC1_BASE;
      OP_JMP: pc1 = PC1_JMP;
      default: is_illegal = 1'b1;  // 0100, 1000, 1101, 1111
    endcase
  end

  assign e_ctrl = pack_e_ctrl(alu, pc1, pc2, op2);

endmodule

// File: rtl/lc3_decode_queue.sv
// LC3 decode stage with a DEPTH-entry output FIFO, flush and illegal-opcode
// filtering/counting between fetch and execute.
module lc3_decode_queue
  import lc3_decode_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 2,
  parameter int ILL_CNT_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_decode,
  input  logic                         flush,
  lc3_decode_queue_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         illegal,
  output logic [ILL_CNT_W-1:0]         illegal_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  decode_entry_t     entry_mem [DEPTH];
  logic [ADDR_W-1:0] npc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  logic [5:0] dec_e;
  logic [1:0] dec_w;
  logic       dec_m;
  logic       dec_ill;
  logic       pop, accept, push, drop;

  lc3_decode_logic u_decode (
    .instr      (bus.instr_in),
    .e_ctrl     (dec_e),
    .w_ctrl     (dec_w),
    .mem_ctrl   (dec_m),
    .is_illegal (dec_ill)
  );

  assign pop          = bus.out_valid & bus.out_ready;
  assign bus.out_valid = (count != '0);
  // A pop this cycle frees the tail slot, so a full queue can still accept.
  assign bus.in_ready = enable_decode & ~flush & ((count < CNT_W'(DEPTH)) | pop);
  assign accept       = bus.in_valid & bus.in_ready;
  assign push         = accept & ~dec_ill;
  assign drop         = accept & dec_ill;

  function automatic logic [PTR_W-1:0] next_ptr(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      illegal <= drop;
      if (drop && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage is not reset; out_valid gates every field read from it.
  always_ff @(posedge clock) begin
    if (push) begin
      entry_mem[wr_ptr] <= '{ir: bus.instr_in, e_ctrl: dec_e, w_ctrl: dec_w, mem_ctrl: dec_m};
      npc_mem[wr_ptr]   <= bus.npc_in;
    end
  end

  decode_entry_t head;
  assign head            = entry_mem[rd_ptr];
  assign bus.IR          = bus.out_valid ? head.ir       : '0;
  assign bus.E_Control   = bus.out_valid ? head.e_ctrl   : '0;
  assign bus.W_Control   = bus.out_valid ? head.w_ctrl   : '0;
  assign bus.Mem_Control = bus.out_valid ? head.mem_ctrl : 1'b0;
  assign bus.npc_out     = bus.out_valid ? npc_mem[rd_ptr] : '0;

endmodule
